// File: rtl/spi_vga_pkg.sv
// spi_vga_pkg
// Shared definitions for the SPI-to-VGA path. Holds the command opcodes
// understood by the byte-level decoder, the default identification byte
// returned on MISO during every command byte, and the decoder state
// encoding.
package spi_vga_pkg;

  localparam logic [7:0] CMD_WRITE       = 8'h01;
  localparam logic [7:0] CMD_READ        = 8'h02;
  localparam logic [7:0] DEFAULT_ID_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_H   = 3'd1,
    ST_ADDR_L   = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_RD_ISSUE = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_RD_DATA  = 3'd6,
    ST_DISCARD  = 3'd7
  } dec_state_e;

  // True for the opcodes the decoder accepts; everything else is an error.
  function automatic logic is_legal_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic two-flop synchronizer for a single asynchronous level signal.
// The reset value is a parameter. Its default of 1 matches an idle
// active-low chip select.
// Ports:
//   i_Clk   - destination clock
//   i_Rst_L - asynchronous active-low reset
//   i_D     - asynchronous input level
//   o_Q     - synchronized level, two i_Clk edges behind i_D
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_D,
  output logic o_Q
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_D;
      sync_q <= meta_q;
    end
  end

  assign o_Q = sync_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// Byte-level command decoder that sits behind SPI_Slave (mode 0). Each
// chip-select frame carries an opcode, a 16-bit address (high byte first)
// and a data burst. The decoder turns each frame into write or read
// accesses on a synchronous memory port. It also feeds the slave's
// transmit-load port: ID_BYTE for the first byte of a frame, and
// prefetched read data during a read burst.
// Ports:
//   i_Clk, i_Rst_L           - system clock, async active-low reset
//   i_RX_DV, i_RX_Byte       - received-byte pulse and data from the slave
//   o_TX_DV, o_TX_Byte       - transmit-byte load pulse and data to the slave
//   i_SPI_CS_n               - raw chip-select pin (asynchronous)
//   o_Mem_Addr, o_Mem_WData  - memory address and write data
//   o_Mem_WE, o_Mem_RE       - one-cycle write and read strobes
//   i_Mem_RData              - read data, valid one cycle after o_Mem_RE
//   o_Busy                   - frame open (synchronized chip select low)
//   o_Cmd_Err                - one-cycle pulse on an unknown opcode
module spi_cmd_decoder
  import spi_vga_pkg::*;
#(
  parameter int         ADDR_W  = 16,
  parameter logic [7:0] ID_BYTE = DEFAULT_ID_BYTE
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  input  logic              i_SPI_CS_n,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [7:0]        o_Mem_WData,
  output logic              o_Mem_WE,
  output logic              o_Mem_RE,
  input  logic [7:0]        i_Mem_RData,
  output logic              o_Busy,
  output logic              o_Cmd_Err
);

  logic cs_n_sync;
  logic cs_act;

  sync_2ff #(.RESET_VAL(1'b1)) u_cs_sync (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_D    (i_SPI_CS_n),
    .o_Q    (cs_n_sync)
  );

  assign cs_act = ~cs_n_sync;

  dec_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic              init_q, init_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              cmd_err_q, cmd_err_d;

  logic [15:0]       addr_full;
  logic              frame_end;

  assign addr_full = {addr_hi_q, i_RX_Byte};

  // A byte arriving in the same cycle the frame closes is still processed.
  // The return to IDLE waits one cycle, because cs_act stays low.
  assign frame_end = !cs_act && (state_q != ST_IDLE) && !i_RX_DV;

  // Next-state and next-output logic. Read strobes are raised on the
  // transition into RD_ISSUE. The memory then returns data while the FSM
  // sits in RD_WAIT, which puts the TX load three cycles after the RX byte.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    addr_hi_d   = addr_hi_q;
    cmd_wr_d    = cmd_wr_q;
    init_d      = 1'b0;
    tx_dv_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    cmd_err_d   = 1'b0;

    if (init_q) begin
      // Preload ID_BYTE so the very first frame after reset starts with it.
      tx_dv_d   = 1'b1;
      tx_byte_d = ID_BYTE;
    end else if (frame_end) begin
      state_d   = ST_IDLE;
      tx_dv_d   = 1'b1;
      tx_byte_d = ID_BYTE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_RX_DV) begin
            if (is_legal_cmd(i_RX_Byte)) begin
              cmd_wr_d = (i_RX_Byte == CMD_WRITE);
              state_d  = ST_ADDR_H;
            end else begin
              cmd_err_d = 1'b1;
              state_d   = ST_DISCARD;
            end
          end
        end
        ST_ADDR_H: begin
          if (i_RX_DV) begin
            addr_hi_d = i_RX_Byte;
            state_d   = ST_ADDR_L;
          end
        end
        ST_ADDR_L: begin
          if (i_RX_DV) begin
            addr_d = addr_full[ADDR_W-1:0];
            if (cmd_wr_q) begin
              state_d = ST_WR_DATA;
            end else begin
              mem_re_d   = 1'b1;
              mem_addr_d = addr_full[ADDR_W-1:0];
              state_d    = ST_RD_ISSUE;
            end
          end
        end
        ST_WR_DATA: begin
          if (i_RX_DV) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = i_RX_Byte;
            mem_addr_d  = addr_q;
            addr_d      = addr_q + ADDR_W'(1);
          end
        end
        ST_RD_ISSUE: begin
          state_d = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          tx_dv_d   = 1'b1;
          tx_byte_d = i_Mem_RData;
          addr_d    = addr_q + ADDR_W'(1);
          state_d   = ST_RD_DATA;
        end
        ST_RD_DATA: begin
          // Dummy byte: fetch the next address for the following MISO slot.
          if (i_RX_DV) begin
            mem_re_d   = 1'b1;
            mem_addr_d = addr_q;
            state_d    = ST_RD_ISSUE;
          end
        end
        ST_DISCARD: begin
          state_d = ST_DISCARD;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // All state and outputs are registered. init_q resets high so the ID
  // preload fires on the first cycle after reset release.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      addr_hi_q   <= 8'h00;
      cmd_wr_q    <= 1'b0;
      init_q      <= 1'b1;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= 8'h00;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      addr_hi_q   <= addr_hi_d;
      cmd_wr_q    <= cmd_wr_d;
      init_q      <= init_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Mem_Addr  = mem_addr_q;
  assign o_Mem_WData = mem_wdata_q;
  assign o_Mem_WE    = mem_we_q;
  assign o_Mem_RE    = mem_re_q;
  assign o_Cmd_Err   = cmd_err_q;
  assign o_Busy      = cs_act;

endmodule
